uart_rx: RTL

Asynchronous serial receiver for the UART: the receive-side counterpart of the transmit shifter and bit-time counter. It detects the start bit and samples each bit at mid-bit-time using the same 4-bit baud-select encoding as the transmitter. It assembles 7- or 8-bit characters with optional parity and presents them to the host with a ready/read handshake plus error flags.

---
 rtl/uart_rx.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: async serial receiver, mid-bit sampling; 7/8 data bits + optional parity when UART_RX_PARITY_EN is defined, else 8N1.
// Character loads 1 clk after the stop sample; no backpressure: an unread character is overwritten and ovf flags it.
module uart_rx #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] baud,
  input  logic       eight,
  input  logic       pen,
  input  logic       ohel,
  input  logic       rx,
  input  logic       read,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       perr,
  output logic       ferr,
  output logic       ovf
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

`ifdef UART_RX_PARITY_EN
  localparam int SW = 9;
`else
  localparam int SW = 8;
`endif

  state_t                  state, state_nxt;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    rx_s;
  logic [18:0]             n_sel, n_q, cnt;
  logic [3:0]              bit_idx, nbits;
  logic [SW-1:0]           shreg;
  logic                    half_hit, full_hit;
  logic                    cnt_clr, shift_en, load, start_det;
  logic [7:0]              data_w;
  logic                    perr_w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end
  assign rx_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    n_sel = 19'd333333;
    case (baud)
      4'd0:  n_sel = 19'd333333;
      4'd1:  n_sel = 19'd83333;
      4'd2:  n_sel = 19'd41667;
      4'd3:  n_sel = 19'd20833;
      4'd4:  n_sel = 19'd10417;
      4'd5:  n_sel = 19'd5208;
      4'd6:  n_sel = 19'd2604;
      4'd7:  n_sel = 19'd1736;
      4'd8:  n_sel = 19'd868;
      4'd9:  n_sel = 19'd434;
      4'd10: n_sel = 19'd217;
      4'd11: n_sel = 19'd109;
      default: n_sel = 19'd333333;
    endcase
  end

  assign half_hit = (cnt == ((n_q >> 1) - 19'd1));
  assign full_hit = (cnt == (n_q - 19'd1));

`ifdef UART_RX_PARITY_EN
  logic       eight_q, pen_q, ohel_q;
  logic [8:0] shr_al;
  logic       pbit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eight_q <= 1'b0;
      pen_q   <= 1'b0;
      ohel_q  <= 1'b0;
    end else if (start_det) begin
      eight_q <= eight;
      pen_q   <= pen;
      ohel_q  <= ohel;
    end
  end

  assign nbits = (eight_q ? 4'd8 : 4'd7) + {3'b000, pen_q};

  // Bits enter at the MSB, so a short frame sits high; shift it down to bit 0.
  always_comb begin
    shr_al = shreg >> (4'd9 - nbits);
    data_w = eight_q ? shr_al[7:0] : {1'b0, shr_al[6:0]};
    pbit   = eight_q ? shr_al[8] : shr_al[7];
    perr_w = pen_q & ((^data_w ^ pbit) != ohel_q);
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{eight, pen, ohel};
  assign nbits      = 4'd8;
  assign data_w     = shreg;
  assign perr_w     = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    shift_en  = 1'b0;
    load      = 1'b0;
    start_det = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          start_det = 1'b1;
          state_nxt = START;
        end
      end
      START: begin
        if (half_hit) state_nxt = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (full_hit) begin
          shift_en = 1'b1;
          cnt_clr  = 1'b1;
          if (bit_idx == nbits - 4'd1) state_nxt = STOP;
        end
      end
      STOP: begin
        // Leaving at mid-stop leaves half a bit to catch a back-to-back start edge.
        if (full_hit) begin
          load      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      n_q     <= 19'd333333;
    end else begin
      state <= state_nxt;
      if (cnt_clr || (state_nxt != state) || (state == IDLE)) cnt <= '0;
      else                                                    cnt <= cnt + 19'd1;
      if (state == START)  bit_idx <= '0;
      else if (shift_en)   bit_idx <= bit_idx + 4'd1;
      if (shift_en)  shreg <= {rx_s, shreg[SW-1:1]};
      if (start_det) n_q   <= n_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data <= 8'h00;
      rx_rdy  <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      ovf     <= 1'b0;
    end else if (load) begin
      rx_data <= data_w;
      ferr    <= ~rx_s;
      perr    <= perr_w;
      rx_rdy  <= 1'b1;
      if (rx_rdy && !read) ovf <= 1'b1;
    end else if (read) begin
      rx_rdy <= 1'b0;
      ovf    <= 1'b0;
    end
  end

endmodule
